// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: command codes, status codes and FSM encoding shared by the command sequencer
package uart_cmd_pkg;

   localparam logic [7:0] CMD_WRITE = 8'h01;
   localparam logic [7:0] CMD_READ  = 8'h02;

   localparam logic [7:0] ST_OK   = 8'h00;
   localparam logic [7:0] ST_NACK = 8'h01;
   localparam logic [7:0] ST_CHK  = 8'h02;
   localparam logic [7:0] ST_CMD  = 8'h03;
   localparam logic [7:0] ST_TMO  = 8'h04;

   typedef enum logic [2:0] {
      S_SYNC,
      S_CMD,
      S_ADDR,
      S_DATA,
      S_CHK,
      S_EXEC,
      S_RESP0,
      S_RESP1
   } state_t;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/cmd_timeout_cnt.sv
// cmd_timeout_cnt: down-counter reloaded with INIT, decrementing while enabled, expire when it reaches zero
module cmd_timeout_cnt #(
   parameter int W    = 10,
   parameter int INIT = 639
) (
   input  logic clk_in,
   input  logic rst,
   input  logic load,
   input  logic en,
   output logic expire
);

   logic [W-1:0] cnt;

   assign expire = (cnt == '0);

   // reload has priority; the count parks at zero until reloaded
   always_ff @(posedge clk_in or posedge rst)
      if (rst) cnt <= '0;
      else if (load) cnt <= W'(INIT);
      else if (en && !expire) cnt <= cnt - W'(1);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: assembles 5-byte host frames, runs one I2C register access, returns status/data bytes
module uart_cmd_ctrl
   import uart_cmd_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE    = 8'hA5,
   parameter int         BYTE_TIMEOUT = 640,
   parameter int         I2C_TIMEOUT  = 4096
) (
   input  logic       clk_in,
   input  logic       rst,
   input  logic       rx_valid,
   input  logic [7:0] rx_data,
   output logic       i2c_req,
   output logic       i2c_rw,
   output logic [7:0] i2c_addr,
   output logic [7:0] i2c_wdata,
   input  logic       i2c_done,
   input  logic       i2c_nack,
   input  logic [7:0] i2c_rdata,
   output logic       tx_valid,
   output logic [7:0] tx_data,
   input  logic       tx_ready,
   output logic       busy,
   output logic [7:0] err_cnt
);

   localparam int GW = $clog2(BYTE_TIMEOUT);
   localparam int IW = $clog2(I2C_TIMEOUT);

   state_t     state;
   logic [7:0] cmd_r;
   logic [7:0] rdata_r;
   logic       gap_act, gap_exp, gap_to;
   logic       exec, i2c_exp;

   assign busy    = (state != S_SYNC);
   assign gap_act = state inside {S_CMD, S_ADDR, S_DATA, S_CHK};
   assign gap_to  = gap_act && gap_exp && !rx_valid;
   assign exec    = (state == S_EXEC);

   cmd_timeout_cnt #(.W(GW), .INIT(BYTE_TIMEOUT - 1)) u_gap (
      .clk_in (clk_in),
      .rst    (rst),
      .load   (rx_valid || !gap_act),
      .en     (gap_act),
      .expire (gap_exp)
   );

   cmd_timeout_cnt #(.W(IW), .INIT(I2C_TIMEOUT - 1)) u_i2c (
      .clk_in (clk_in),
      .rst    (rst),
      .load   (!exec),
      .en     (exec),
      .expire (i2c_exp)
   );

   // frame sequencer: byte collection, I2C execution and response hand-off with registered outputs
   always_ff @(posedge clk_in or posedge rst)
      if (rst) begin
         state     <= S_SYNC;
         cmd_r     <= '0;
         rdata_r   <= '0;
         i2c_req   <= 1'b0;
         i2c_rw    <= 1'b0;
         i2c_addr  <= '0;
         i2c_wdata <= '0;
         tx_valid  <= 1'b0;
         tx_data   <= '0;
         err_cnt   <= '0;
      end else if (gap_to) begin
         state   <= S_SYNC;
         err_cnt <= sat_inc(err_cnt);
      end else begin
         case (state)
            S_SYNC:
               if (rx_valid && rx_data == SYNC_BYTE) state <= S_CMD;
            S_CMD:
               if (rx_valid) begin
                  cmd_r <= rx_data;
                  state <= S_ADDR;
               end
            S_ADDR:
               if (rx_valid) begin
                  i2c_addr <= rx_data;
                  state    <= S_DATA;
               end
            S_DATA:
               if (rx_valid) begin
                  i2c_wdata <= rx_data;
                  state     <= S_CHK;
               end
            S_CHK:
               if (rx_valid) begin
                  if (rx_data != (cmd_r ^ i2c_addr ^ i2c_wdata)) begin
                     tx_valid <= 1'b1;
                     tx_data  <= ST_CHK;
                     err_cnt  <= sat_inc(err_cnt);
                     state    <= S_RESP0;
                  end else if (cmd_r != CMD_WRITE && cmd_r != CMD_READ) begin
                     tx_valid <= 1'b1;
                     tx_data  <= ST_CMD;
                     err_cnt  <= sat_inc(err_cnt);
                     state    <= S_RESP0;
                  end else begin
                     i2c_req <= 1'b1;
                     i2c_rw  <= (cmd_r == CMD_READ);
                     state   <= S_EXEC;
                  end
               end
            S_EXEC:
               if (i2c_done) begin
                  i2c_req  <= 1'b0;
                  rdata_r  <= i2c_rdata;
                  tx_valid <= 1'b1;
                  tx_data  <= i2c_nack ? ST_NACK : ST_OK;
                  state    <= S_RESP0;
               end else if (i2c_exp) begin
                  i2c_req  <= 1'b0;
                  tx_valid <= 1'b1;
                  tx_data  <= ST_TMO;
                  state    <= S_RESP0;
               end
            S_RESP0:
               if (tx_ready) begin
                  if (i2c_rw && tx_data == ST_OK) begin
                     tx_data <= rdata_r;
                     state   <= S_RESP1;
                  end else begin
                     tx_valid <= 1'b0;
                     state    <= S_SYNC;
                  end
               end
            S_RESP1:
               if (tx_ready) begin
                  tx_valid <= 1'b0;
                  state    <= S_SYNC;
               end
            default:
               state <= S_SYNC;
         endcase
      end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb_uart_cmd_ctrl: directed scenario tests for the UART command sequencer
module tb_uart_cmd_ctrl;

   logic       clk_in = 1'b0;
   logic       rst = 1'b1;
   logic       rx_valid = 1'b0;
   logic [7:0] rx_data = '0;
   logic       i2c_req, i2c_rw;
   logic [7:0] i2c_addr, i2c_wdata;
   logic       i2c_done = 1'b0;
   logic       i2c_nack = 1'b0;
   logic [7:0] i2c_rdata = '0;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_ready = 1'b0;
   logic       busy;
   logic [7:0] err_cnt;

   int errors = 0;
   int checks = 0;

   uart_cmd_ctrl dut (
      .clk_in    (clk_in),
      .rst       (rst),
      .rx_valid  (rx_valid),
      .rx_data   (rx_data),
      .i2c_req   (i2c_req),
      .i2c_rw    (i2c_rw),
      .i2c_addr  (i2c_addr),
      .i2c_wdata (i2c_wdata),
      .i2c_done  (i2c_done),
      .i2c_nack  (i2c_nack),
      .i2c_rdata (i2c_rdata),
      .tx_valid  (tx_valid),
      .tx_data   (tx_data),
      .tx_ready  (tx_ready),
      .busy      (busy),
      .err_cnt   (err_cnt)
   );

   initial forever #5 clk_in = ~clk_in;

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk_in);
      rx_valid = 1'b1;
      rx_data  = b;
      @(negedge clk_in);
      rx_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] d, input logic [7:0] k);
      send_byte(8'hA5);
      send_byte(c);
      send_byte(a);
      send_byte(d);
      send_byte(k);
   endtask

   task automatic pulse_done(input logic nack, input logic [7:0] rd);
      i2c_done  = 1'b1;
      i2c_nack  = nack;
      i2c_rdata = rd;
      @(negedge clk_in);
      i2c_done  = 1'b0;
      i2c_nack  = 1'b0;
      i2c_rdata = '0;
   endtask

   task automatic wait_tx();
      for (int i = 0; i < 20 && !tx_valid; i++) @(negedge clk_in);
   endtask

   task automatic accept_tx();
      tx_ready = 1'b1;
      @(negedge clk_in);
      tx_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk_in);
      checks++;
      if ({i2c_req, i2c_rw, i2c_addr, i2c_wdata, tx_valid, tx_data, busy, err_cnt} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got req=%b rw=%b addr=%h wd=%h txv=%b txd=%h busy=%b err=%h want all 0",
                  i2c_req, i2c_rw, i2c_addr, i2c_wdata, tx_valid, tx_data, busy, err_cnt);
      end
      rst = 1'b0;
      @(negedge clk_in);
   endtask

   task automatic test_write();
      send_frame(8'h01, 8'h6B, 8'h00, 8'h6A);
      checks++;
      if ({i2c_req, i2c_rw, i2c_addr, i2c_wdata, busy} !== {1'b1, 1'b0, 8'h6B, 8'h00, 1'b1}) begin
         errors++;
         $display("FAIL write_req: got req=%b rw=%b addr=%h wd=%h busy=%b want 1 0 6b 00 1", i2c_req, i2c_rw, i2c_addr, i2c_wdata, busy);
      end
      pulse_done(1'b0, 8'h00);
      checks++;
      if ({i2c_req, tx_valid, tx_data} !== {1'b0, 1'b1, 8'h00}) begin
         errors++;
         $display("FAIL write_status: got req=%b txv=%b txd=%h want 0 1 00", i2c_req, tx_valid, tx_data);
      end
      accept_tx();
      checks++;
      if ({tx_valid, busy} !== 2'b00) begin
         errors++;
         $display("FAIL write_single_byte: got txv=%b busy=%b want 0 0", tx_valid, busy);
      end
   endtask

   task automatic test_read();
      send_frame(8'h02, 8'h75, 8'h00, 8'h77);
      checks++;
      if ({i2c_req, i2c_rw, i2c_addr} !== {1'b1, 1'b1, 8'h75}) begin
         errors++;
         $display("FAIL read_req: got req=%b rw=%b addr=%h want 1 1 75", i2c_req, i2c_rw, i2c_addr);
      end
      pulse_done(1'b0, 8'h68);
      for (int i = 0; i < 5; i++) begin
         checks++;
         if ({tx_valid, tx_data} !== {1'b1, 8'h00}) begin
            errors++;
            $display("FAIL read_status_hold%0d: got txv=%b txd=%h want 1 00", i, tx_valid, tx_data);
         end
         @(negedge clk_in);
      end
      accept_tx();
      checks++;
      if ({tx_valid, tx_data} !== {1'b1, 8'h68}) begin
         errors++;
         $display("FAIL read_data: got txv=%b txd=%h want 1 68", tx_valid, tx_data);
      end
      accept_tx();
      checks++;
      if ({tx_valid, busy} !== 2'b00) begin
         errors++;
         $display("FAIL read_end: got txv=%b busy=%b want 0 0", tx_valid, busy);
      end
   endtask

   task automatic test_bad_frames();
      send_frame(8'h01, 8'h6B, 8'h00, 8'hFF);
      checks++;
      if ({i2c_req, tx_valid, tx_data, err_cnt} !== {1'b0, 1'b1, 8'h02, 8'd1}) begin
         errors++;
         $display("FAIL bad_chk: got req=%b txv=%b txd=%h err=%0d want 0 1 02 1", i2c_req, tx_valid, tx_data, err_cnt);
      end
      accept_tx();
      send_frame(8'h07, 8'h10, 8'h20, 8'h37);
      checks++;
      if ({i2c_req, tx_valid, tx_data, err_cnt} !== {1'b0, 1'b1, 8'h03, 8'd2}) begin
         errors++;
         $display("FAIL bad_cmd: got req=%b txv=%b txd=%h err=%0d want 0 1 03 2", i2c_req, tx_valid, tx_data, err_cnt);
      end
      accept_tx();
      checks++;
      if ({tx_valid, busy} !== 2'b00) begin
         errors++;
         $display("FAIL bad_end: got txv=%b busy=%b want 0 0", tx_valid, busy);
      end
   endtask

   task automatic test_byte_timeout();
      send_byte(8'hA5);
      send_byte(8'h01);
      repeat (639) @(negedge clk_in);
      checks++;
      if ({busy, err_cnt} !== {1'b1, 8'd2}) begin
         errors++;
         $display("FAIL gap_before_expiry: got busy=%b err=%0d want 1 2", busy, err_cnt);
      end
      @(negedge clk_in);
      checks++;
      if ({busy, tx_valid, err_cnt} !== {1'b0, 1'b0, 8'd3}) begin
         errors++;
         $display("FAIL gap_expired: got busy=%b txv=%b err=%0d want 0 0 3", busy, tx_valid, err_cnt);
      end
      send_byte(8'hA5);
      repeat (638) @(negedge clk_in);
      send_byte(8'h01);
      send_byte(8'h6B);
      send_byte(8'h00);
      send_byte(8'h6A);
      checks++;
      if ({i2c_req, i2c_addr, err_cnt} !== {1'b1, 8'h6B, 8'd3}) begin
         errors++;
         $display("FAIL gap_edge_byte_wins: got req=%b addr=%h err=%0d want 1 6b 3", i2c_req, i2c_addr, err_cnt);
      end
      pulse_done(1'b0, 8'h00);
      wait_tx();
      checks++;
      if ({tx_valid, tx_data} !== {1'b1, 8'h00}) begin
         errors++;
         $display("FAIL gap_recovery_status: got txv=%b txd=%h want 1 00", tx_valid, tx_data);
      end
      accept_tx();
   endtask

   task automatic test_i2c_errors();
      send_frame(8'h01, 8'h1B, 8'h18, 8'h02);
      repeat (4095) @(negedge clk_in);
      checks++;
      if ({i2c_req, tx_valid} !== 2'b10) begin
         errors++;
         $display("FAIL i2c_before_timeout: got req=%b txv=%b want 1 0", i2c_req, tx_valid);
      end
      @(negedge clk_in);
      checks++;
      if ({i2c_req, tx_valid, tx_data} !== {1'b0, 1'b1, 8'h04}) begin
         errors++;
         $display("FAIL i2c_timeout: got req=%b txv=%b txd=%h want 0 1 04", i2c_req, tx_valid, tx_data);
      end
      accept_tx();
      send_frame(8'h01, 8'h1B, 8'h18, 8'h02);
      repeat (3) @(negedge clk_in);
      pulse_done(1'b1, 8'h00);
      checks++;
      if ({i2c_req, tx_valid, tx_data, err_cnt} !== {1'b0, 1'b1, 8'h01, 8'd3}) begin
         errors++;
         $display("FAIL i2c_nack: got req=%b txv=%b txd=%h err=%0d want 0 1 01 3", i2c_req, tx_valid, tx_data, err_cnt);
      end
      accept_tx();
      checks++;
      if ({tx_valid, busy} !== 2'b00) begin
         errors++;
         $display("FAIL nack_end: got txv=%b busy=%b want 0 0", tx_valid, busy);
      end
   endtask

   task automatic test_noise_reset();
      send_byte(8'h00);
      send_byte(8'hFF);
      checks++;
      if ({busy, err_cnt} !== {1'b0, 8'd3}) begin
         errors++;
         $display("FAIL noise_ignored: got busy=%b err=%0d want 0 3", busy, err_cnt);
      end
      send_frame(8'h01, 8'h6B, 8'h00, 8'h6A);
      checks++;
      if ({i2c_req, busy} !== 2'b11) begin
         errors++;
         $display("FAIL noise_then_frame: got req=%b busy=%b want 1 1", i2c_req, busy);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({i2c_req, tx_valid, err_cnt, busy} !== '0) begin
         errors++;
         $display("FAIL async_reset: got req=%b txv=%b err=%0d busy=%b want 0 0 0 0", i2c_req, tx_valid, err_cnt, busy);
      end
      @(negedge clk_in);
      rst = 1'b0;
      send_frame(8'h02, 8'h75, 8'h00, 8'h77);
      pulse_done(1'b0, 8'h68);
      accept_tx();
      checks++;
      if ({tx_valid, tx_data} !== {1'b1, 8'h68}) begin
         errors++;
         $display("FAIL post_reset_read: got txv=%b txd=%h want 1 68", tx_valid, tx_data);
      end
      accept_tx();
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_bad_frames();
      test_byte_timeout();
      test_i2c_errors();
      test_noise_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_cmd_ctrl.md
Name: uart_cmd_ctrl

Overview:
Command sequencer between the UART receiver and the I2C master driving the MPU6050. It assembles 5-byte frames from the receiver's byte stream, checks them, and issues one register write or read to the I2C master. It then returns a status byte, plus a data byte for reads, to the UART transmitter. It is the only block that configures the sensor from the host link.

Parameters:
SYNC_BYTE, 8'hA5, first byte of every frame
BYTE_TIMEOUT, 640, max clk_in cycles between consecutive frame bytes (4 byte-times at 16x oversampling)
I2C_TIMEOUT, 4096, max clk_in cycles waiting for i2c_done after i2c_req rises

Ports:
clk_in  in  1  clock; same oversampled clock as the UART receiver
rst  in  1  asynchronous, active-high reset
rx_valid  in  1  one-cycle pulse: rx_data holds a new received byte
rx_data  in  8  received byte
i2c_req  out  1  request level; held high until i2c_done or timeout
i2c_rw  out  1  0 = register write, 1 = register read; stable while i2c_req is high
i2c_addr  out  8  MPU6050 register address; stable while i2c_req is high
i2c_wdata  out  8  write data; stable while i2c_req is high
i2c_done  in  1  one-cycle pulse: transaction finished
i2c_nack  in  1  qualified by i2c_done: slave NACKed
i2c_rdata  in  8  qualified by i2c_done: read data
tx_valid  out  1  response byte valid
tx_data  out  8  response byte; stable while tx_valid is high
tx_ready  in  1  transmitter accepts the byte when tx_valid && tx_ready
busy  out  1  high in every state except S_SYNC
err_cnt  out  8  saturating count of frame errors (checksum, bad cmd, byte timeout)

Behaviour:
- Reset: state S_SYNC. All outputs 0. Internal byte and gap counters 0.
- Frame layout: SYNC, CMD, ADDR, DATA, CHK, with CHK = CMD ^ ADDR ^ DATA.
  - CMD 8'h01 is write; DATA is the write value.
  - CMD 8'h02 is read; DATA is ignored but still present and included in CHK.
- States: S_SYNC, S_CMD, S_ADDR, S_DATA, S_CHK, S_EXEC, S_RESP0, S_RESP1.
- S_SYNC: on rx_valid with rx_data == SYNC_BYTE, go to S_CMD. Any other byte is discarded silently, with no err_cnt change.
- S_CMD, S_ADDR, S_DATA: each rx_valid latches the byte and advances one state.
- S_CHK, on rx_valid:
  - checksum mismatch: status 8'h02, err_cnt+1, go to S_RESP0.
  - CMD not 01 or 02: status 8'h03, err_cnt+1, go to S_RESP0.
  - otherwise go to S_EXEC. i2c_req rises the cycle after the CHK byte's rx_valid.
- Byte timeout:
  - A gap counter is cleared on every rx_valid and active only in S_CMD..S_CHK.
  - When it reaches BYTE_TIMEOUT-1 with no rx_valid: return to S_SYNC, err_cnt+1, no response.
  - rx_valid in the same cycle as expiry wins (byte accepted, counter cleared).
- S_EXEC:
  - i2c_req = 1; i2c_rw, i2c_addr and i2c_wdata come from the latched frame.
  - On i2c_done: i2c_req drops the next cycle. Status is 8'h00, or 8'h01 if i2c_nack. i2c_rdata is latched. Go to S_RESP0.
  - If I2C_TIMEOUT cycles pass with no i2c_done: drop i2c_req, status 8'h04, go to S_RESP0.
- S_RESP0: tx_valid = 1, tx_data = status. On tx_ready:
  - go to S_RESP1 for a read with status 00;
  - otherwise go to S_SYNC.
- S_RESP1: tx_valid = 1, tx_data = latched read data. On tx_ready, go to S_SYNC.
- rx_valid in S_EXEC, S_RESP0 or S_RESP1 is dropped, with no err_cnt change. There is no overlap between frames.
- err_cnt saturates at 8'hFF.
- Reset asserted mid-frame or mid-transaction: immediate return to reset values. i2c_req falls asynchronously.
- Minimum read latency: i2c_req rises 1 cycle after CHK, and tx_valid rises 1 cycle after i2c_done.

Decomposition:
- Shared package uart_cmd_pkg holds:
  - CMD_WRITE = 8'h01 and CMD_READ = 8'h02;
  - status codes ST_OK = 00, ST_NACK = 01, ST_CHK = 02, ST_CMD = 03, ST_TMO = 04;
  - the state encoding.
- One sub-module, cmd_timeout_cnt: a parameterised down-counter with load, enable and expire. It is instantiated twice, once for the byte gap and once for the I2C wait.

Test Plan:
- Write frame: A5 01 6B 00 6A, i2c_done with nack=0 -> i2c_req=1 with rw=0, addr=6B, wdata=00; then a single tx byte 00.
- Read frame: A5 02 75 00 77, i2c_done with rdata=68 -> tx bytes 00 then 68; tx_ready held low 5 cycles keeps tx_valid and tx_data stable.
- Bad checksum: A5 01 6B 00 FF -> no i2c_req, tx byte 02, err_cnt=1.
- Byte timeout: A5 01, then silence for 640 cycles -> back to S_SYNC, busy=0, err_cnt+1, no tx; a following A5 01 6B 00 6A executes normally.
- I2C hang and NACK: valid write with no i2c_done for 4096 cycles -> i2c_req falls, tx byte 04; repeated with i2c_done and nack=1 -> tx byte 01.
- Noise and reset: bytes 00 FF before A5 are ignored; rst pulse in S_EXEC -> i2c_req, tx_valid and err_cnt all 0 immediately.
